// File: rtl/addsub_checker.sv
// addsub_checker: on-chip response monitor for an 8-bit adder/subtractor.
// Each accepted vector is checked against a built-in reference model. The
// block counts vectors and mismatches and reports a pass/fail verdict when
// the run ends.
// Optional feature: define ADDSUB_CHK_CAPTURE_EN to keep the first failing
// vector in the fail_* registers. When it is undefined, fail_* are tied to 0.
module addsub_checker #(
   parameter int WIDTH       = 8,
   parameter int NUM_VECTORS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] inp1,
   input  logic [WIDTH-1:0] inp2,
   input  logic             carryin,
   input  logic [WIDTH-1:0] sum,
   input  logic             carryout,
   output logic             chk_valid,
   output logic             chk_err,
   output logic [15:0]      vec_cnt,
   output logic [15:0]      err_cnt,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] fail_inp1,
   output logic [WIDTH-1:0] fail_inp2,
   output logic             fail_mode,
   output logic [WIDTH:0]   fail_got,
   output logic [WIDTH:0]   fail_exp
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

   state_t         state_q, state_d;
   logic [15:0]    vec_cnt_q, vec_cnt_d;
   logic [15:0]    err_cnt_q, err_cnt_d;
   logic           chk_valid_q, chk_valid_d;
   logic           chk_err_q, chk_err_d;
   logic [WIDTH:0] exp_w;
   logic           mismatch;
   logic           accept;
   logic           last_vec;

   // Reference model. In subtract mode the adder computes A + ~B + 1, so a
   // carry of 1 means there was no borrow.
   always_comb begin
      exp_w    = {1'b0, inp1} + {1'b0, (carryin ? ~inp2 : inp2)} + {{WIDTH{1'b0}}, carryin};
      mismatch = ({carryout, sum} != exp_w);
   end

   // A start pulse takes priority, so a vector that arrives in the same
   // cycle as start is dropped.
   assign accept   = (state_q == RUN) && in_valid && !start;
   assign last_vec = accept && (vec_cnt_q == LAST_IDX);

   // Next-state logic for the run-control FSM.
   always_comb begin
      // NOTE: give every always_comb output a default first, so no path
      // leaves it unassigned and infers a latch.
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = IDLE;
         RUN:     if (last_vec || stop) state_d = DRAIN;
         DRAIN:   state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
      if (start) state_d = RUN;
   end

   // Next values for the counters and the registered compare stage. err_cnt
   // follows the chk_err pulse by one cycle and saturates at its maximum.
   always_comb begin
      vec_cnt_d   = vec_cnt_q;
      err_cnt_d   = err_cnt_q;
      chk_valid_d = accept;
      chk_err_d   = accept && mismatch;
      if (accept) vec_cnt_d = vec_cnt_q + 16'd1;
      if (chk_err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
      if (start) begin
         vec_cnt_d   = '0;
         err_cnt_d   = '0;
         chk_valid_d = 1'b0;
         chk_err_d   = 1'b0;
      end
   end

   // State and datapath registers. An asynchronous reset also clears any
   // compare that is still in flight.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the values from before the clock edge.
      if (rst) begin
         state_q     <= IDLE;
         vec_cnt_q   <= '0;
         err_cnt_q   <= '0;
         chk_valid_q <= 1'b0;
         chk_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         vec_cnt_q   <= vec_cnt_d;
         err_cnt_q   <= err_cnt_d;
         chk_valid_q <= chk_valid_d;
         chk_err_q   <= chk_err_d;
      end
   end

   assign chk_valid = chk_valid_q;
   assign chk_err   = chk_err_q;
   assign vec_cnt   = vec_cnt_q;
   assign err_cnt   = err_cnt_q;
   assign done      = (state_q == DONE);
   assign pass      = done && (err_cnt_q == 16'd0);

`ifdef ADDSUB_CHK_CAPTURE_EN
   logic             captured_q;
   logic [WIDTH-1:0] fail_inp1_q, fail_inp2_q;
   logic             fail_mode_q;
   logic [WIDTH:0]   fail_got_q, fail_exp_q;

   // Capture the first failing vector of a run. The registers update on the
   // same edge that raises chk_err and are not overwritten until the next run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         captured_q  <= 1'b0;
         fail_inp1_q <= '0;
         fail_inp2_q <= '0;
         fail_mode_q <= 1'b0;
         fail_got_q  <= '0;
         fail_exp_q  <= '0;
      end else if (start) begin
         captured_q  <= 1'b0;
         fail_inp1_q <= '0;
         fail_inp2_q <= '0;
         fail_mode_q <= 1'b0;
         fail_got_q  <= '0;
         fail_exp_q  <= '0;
      end else if (accept && mismatch && !captured_q) begin
         captured_q  <= 1'b1;
         fail_inp1_q <= inp1;
         fail_inp2_q <= inp2;
         fail_mode_q <= carryin;
         fail_got_q  <= {carryout, sum};
         fail_exp_q  <= exp_w;
      end
   end

   assign fail_inp1 = fail_inp1_q;
   assign fail_inp2 = fail_inp2_q;
   assign fail_mode = fail_mode_q;
   assign fail_got  = fail_got_q;
   assign fail_exp  = fail_exp_q;
`else
   assign fail_inp1 = '0;
   assign fail_inp2 = '0;
   assign fail_mode = 1'b0;
   assign fail_got  = '0;
   assign fail_exp  = '0;
`endif

endmodule

// File: tb/tb_addsub_checker.sv
// tb_addsub_checker: directed-vector bench for addsub_checker.
// Instance "a" is built with NUM_VECTORS=3 and instance "b" with
// NUM_VECTORS=65535. Both instances share the same stimulus.
// The fail_* expectations depend on ADDSUB_CHK_CAPTURE_EN.
module tb_addsub_checker;

`ifdef ADDSUB_CHK_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic       clk, rst, start, stop, in_valid, carryin, carryout;
   logic [7:0] inp1, inp2, sum;

   logic       a_chk_valid, a_chk_err, a_done, a_pass, a_fail_mode;
   logic [15:0] a_vec_cnt, a_err_cnt;
   logic [7:0] a_fail_inp1, a_fail_inp2;
   logic [8:0] a_fail_got, a_fail_exp;

   logic       b_chk_valid, b_chk_err, b_done, b_pass, b_fail_mode;
   logic [15:0] b_vec_cnt, b_err_cnt;
   logic [7:0] b_fail_inp1, b_fail_inp2;
   logic [8:0] b_fail_got, b_fail_exp;

   logic [70:0] a_all, b_all;
   assign a_all = {a_chk_valid, a_chk_err, a_vec_cnt, a_err_cnt, a_done, a_pass,
                   a_fail_inp1, a_fail_inp2, a_fail_mode, a_fail_got, a_fail_exp};
   assign b_all = {b_chk_valid, b_chk_err, b_vec_cnt, b_err_cnt, b_done, b_pass,
                   b_fail_inp1, b_fail_inp2, b_fail_mode, b_fail_got, b_fail_exp};

   int checks = 0;
   int errors = 0;

   addsub_checker #(.WIDTH(8), .NUM_VECTORS(3)) u_a (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
      .inp1(inp1), .inp2(inp2), .carryin(carryin), .sum(sum), .carryout(carryout),
      .chk_valid(a_chk_valid), .chk_err(a_chk_err), .vec_cnt(a_vec_cnt),
      .err_cnt(a_err_cnt), .done(a_done), .pass(a_pass),
      .fail_inp1(a_fail_inp1), .fail_inp2(a_fail_inp2), .fail_mode(a_fail_mode),
      .fail_got(a_fail_got), .fail_exp(a_fail_exp));

   addsub_checker #(.WIDTH(8), .NUM_VECTORS(65535)) u_b (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
      .inp1(inp1), .inp2(inp2), .carryin(carryin), .sum(sum), .carryout(carryout),
      .chk_valid(b_chk_valid), .chk_err(b_chk_err), .vec_cnt(b_vec_cnt),
      .err_cnt(b_err_cnt), .done(b_done), .pass(b_pass),
      .fail_inp1(b_fail_inp1), .fail_inp2(b_fail_inp2), .fail_mode(b_fail_mode),
      .fail_got(b_fail_got), .fail_exp(b_fail_exp));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge. Inputs are driven
   // and outputs are sampled at that point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic m,
                       input logic [7:0] s, input logic co);
      inp1 = a; inp2 = b; carryin = m; sum = s; carryout = co; in_valid = 1'b1;
      step();
   endtask

   task automatic pulse_start();
      in_valid = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      checks++;
      if (a_all !== 71'd0) begin errors++; $display("FAIL reset_a: got %h want 0", a_all); end
      checks++;
      if (b_all !== 71'd0) begin errors++; $display("FAIL reset_b: got %h want 0", b_all); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      pulse_start();
      send(8'd1, 8'd18, 1'b0, 8'd19, 1'b0);
      checks++;
      if ({a_chk_valid, a_chk_err, a_vec_cnt} !== {1'b1, 1'b0, 16'd1}) begin
         errors++; $display("FAIL basic_v1: valid/err/vec=%b/%b/%0d want 1/0/1", a_chk_valid, a_chk_err, a_vec_cnt);
      end
      send(8'd73, 8'd85, 1'b1, 8'hF4, 1'b0);
      checks++;
      if ({a_chk_valid, a_chk_err, a_vec_cnt} !== {1'b1, 1'b0, 16'd2}) begin
         errors++; $display("FAIL basic_v2: valid/err/vec=%b/%b/%0d want 1/0/2", a_chk_valid, a_chk_err, a_vec_cnt);
      end
      send(8'd7, 8'd5, 1'b0, 8'd12, 1'b0);
      in_valid = 1'b0;
      checks++;
      if ({a_chk_valid, a_chk_err, a_vec_cnt, a_done} !== {1'b1, 1'b0, 16'd3, 1'b0}) begin
         errors++; $display("FAIL basic_v3: valid/err/vec/done=%b/%b/%0d/%b want 1/0/3/0", a_chk_valid, a_chk_err, a_vec_cnt, a_done);
      end
      step();
      checks++;
      if ({a_chk_valid, a_done, a_pass, a_err_cnt, a_vec_cnt} !== {1'b0, 1'b1, 1'b1, 16'd0, 16'd3}) begin
         errors++; $display("FAIL basic_done: valid/done/pass/err/vec=%b/%b/%b/%0d/%0d want 0/1/1/0/3", a_chk_valid, a_done, a_pass, a_err_cnt, a_vec_cnt);
      end
      checks++;
      if ({b_vec_cnt, b_done} !== {16'd3, 1'b0}) begin
         errors++; $display("FAIL basic_b_running: vec/done=%0d/%b want 3/0", b_vec_cnt, b_done);
      end
   endtask

   task automatic test_boundary();
      pulse_start();
      send(8'd255, 8'd1, 1'b0, 8'd0, 1'b1);
      checks++;
      if ({b_chk_valid, b_chk_err} !== 2'b10) begin
         errors++; $display("FAIL bound_add_ok: valid/err=%b/%b want 1/0", b_chk_valid, b_chk_err);
      end
      send(8'd85, 8'd73, 1'b1, 8'd12, 1'b1);
      checks++;
      if ({b_chk_valid, b_chk_err} !== 2'b10) begin
         errors++; $display("FAIL bound_sub_ok: valid/err=%b/%b want 1/0", b_chk_valid, b_chk_err);
      end
      send(8'd255, 8'd1, 1'b0, 8'd0, 1'b0);
      checks++;
      if ({b_chk_valid, b_chk_err, b_err_cnt} !== {2'b11, 16'd0}) begin
         errors++; $display("FAIL bound_add_bad: valid/err/errcnt=%b/%b/%0d want 1/1/0", b_chk_valid, b_chk_err, b_err_cnt);
      end
      send(8'd85, 8'd73, 1'b1, 8'd12, 1'b0);
      in_valid = 1'b0;
      checks++;
      if ({b_chk_valid, b_chk_err, b_err_cnt} !== {2'b11, 16'd1}) begin
         errors++; $display("FAIL bound_sub_bad: valid/err/errcnt=%b/%b/%0d want 1/1/1", b_chk_valid, b_chk_err, b_err_cnt);
      end
      step();
      checks++;
      if ({b_chk_valid, b_err_cnt, b_vec_cnt} !== {1'b0, 16'd2, 16'd4}) begin
         errors++; $display("FAIL bound_errcnt: valid/errcnt/vec=%b/%0d/%0d want 0/2/4", b_chk_valid, b_err_cnt, b_vec_cnt);
      end
      stop = 1'b1; step(); stop = 1'b0;
      step();
      checks++;
      if ({b_done, b_pass} !== 2'b10) begin
         errors++; $display("FAIL bound_verdict: done/pass=%b/%b want 1/0", b_done, b_pass);
      end
      checks++;
      if ({b_fail_inp1, b_fail_inp2, b_fail_mode, b_fail_got, b_fail_exp} !==
          (CAP ? {8'd255, 8'd1, 1'b0, 9'h000, 9'h100} : 35'd0)) begin
         errors++; $display("FAIL bound_capture: got %h/%h/%b/%h/%h", b_fail_inp1, b_fail_inp2, b_fail_mode, b_fail_got, b_fail_exp);
      end
   endtask

   task automatic test_capture();
      pulse_start();
      checks++;
      if ({b_fail_got, b_fail_exp, b_err_cnt} !== 34'd0) begin
         errors++; $display("FAIL capture_cleared: got/exp/errcnt=%h/%h/%0d want 0/0/0", b_fail_got, b_fail_exp, b_err_cnt);
      end
      send(8'd7, 8'd5, 1'b0, 8'd13, 1'b0);
      checks++;
      if ({b_chk_err, b_fail_inp1, b_fail_got, b_fail_exp} !==
          {1'b1, (CAP ? {8'd7, 9'h00D, 9'h00C} : 26'd0)}) begin
         errors++; $display("FAIL capture_first: err/inp1/got/exp=%b/%0d/%h/%h", b_chk_err, b_fail_inp1, b_fail_got, b_fail_exp);
      end
      send(8'd1, 8'd1, 1'b0, 8'd5, 1'b0);
      in_valid = 1'b0;
      checks++;
      if ({b_chk_err, b_fail_inp1, b_fail_inp2, b_fail_mode, b_fail_got, b_fail_exp} !==
          {1'b1, (CAP ? {8'd7, 8'd5, 1'b0, 9'h00D, 9'h00C} : 35'd0)}) begin
         errors++; $display("FAIL capture_hold: err/inp1/inp2/mode/got/exp=%b/%0d/%0d/%b/%h/%h", b_chk_err, b_fail_inp1, b_fail_inp2, b_fail_mode, b_fail_got, b_fail_exp);
      end
      step();
   endtask

   task automatic test_stop();
      pulse_start();
      send(8'd10, 8'd20, 1'b0, 8'd30, 1'b0);
      send(8'd20, 8'd10, 1'b1, 8'd10, 1'b1);
      in_valid = 1'b0;
      stop = 1'b1; step(); stop = 1'b0;
      checks++;
      if ({b_done, b_vec_cnt} !== {1'b0, 16'd2}) begin
         errors++; $display("FAIL stop_drain: done/vec=%b/%0d want 0/2", b_done, b_vec_cnt);
      end
      step();
      checks++;
      if ({b_done, b_pass, b_vec_cnt, b_err_cnt} !== {2'b11, 16'd2, 16'd0}) begin
         errors++; $display("FAIL stop_done: done/pass/vec/err=%b/%b/%0d/%0d want 1/1/2/0", b_done, b_pass, b_vec_cnt, b_err_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         send(8'(i), 8'd3, 1'b0, 8'd99, 1'b1);
         checks++;
         if ({b_chk_valid, b_vec_cnt, b_err_cnt, b_done} !== {1'b0, 16'd2, 16'd0, 1'b1}) begin
            errors++; $display("FAIL done_ignore_%0d: valid/vec/err/done=%b/%0d/%0d/%b want 0/2/0/1", i, b_chk_valid, b_vec_cnt, b_err_cnt, b_done);
         end
      end
      in_valid = 1'b0;
      step();
      checks++;
      if ({b_chk_valid, b_err_cnt} !== {1'b0, 16'd0}) begin
         errors++; $display("FAIL done_ignore_after: valid/err=%b/%0d want 0/0", b_chk_valid, b_err_cnt);
      end
   endtask

   task automatic test_start_drop();
      pulse_start();
      send(8'd1, 8'd1, 1'b0, 8'd2, 1'b0);
      checks++;
      if (b_vec_cnt !== 16'd1) begin
         errors++; $display("FAIL drop_pre: vec=%0d want 1", b_vec_cnt);
      end
      start = 1'b1;
      send(8'd1, 8'd1, 1'b0, 8'd9, 1'b0);
      start = 1'b0; in_valid = 1'b0;
      checks++;
      if ({b_chk_valid, b_vec_cnt, b_err_cnt, b_done} !== {1'b0, 16'd0, 16'd0, 1'b0}) begin
         errors++; $display("FAIL drop_start: valid/vec/err/done=%b/%0d/%0d/%b want 0/0/0/0", b_chk_valid, b_vec_cnt, b_err_cnt, b_done);
      end
      step();
      checks++;
      if ({b_chk_valid, b_chk_err, b_vec_cnt, b_err_cnt} !== {2'b00, 16'd0, 16'd0}) begin
         errors++; $display("FAIL drop_after: valid/err/vec/errcnt=%b/%b/%0d/%0d want 0/0/0/0", b_chk_valid, b_chk_err, b_vec_cnt, b_err_cnt);
      end
   endtask

   task automatic test_rst_midrun();
      send(8'd7, 8'd5, 1'b0, 8'd13, 1'b0);
      in_valid = 1'b0;
      checks++;
      if ({b_chk_valid, b_chk_err} !== 2'b11) begin
         errors++; $display("FAIL rst_pre: valid/err=%b/%b want 1/1", b_chk_valid, b_chk_err);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (b_all !== 71'd0) begin errors++; $display("FAIL rst_async_b: got %h want 0", b_all); end
      step();
      checks++;
      if ({a_all, b_all} !== 142'd0) begin errors++; $display("FAIL rst_hold: a=%h b=%h want 0", a_all, b_all); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_saturation();
      pulse_start();
      for (int i = 0; i < 65535; i++) send(8'd0, 8'd0, 1'b0, 8'd1, 1'b0);
      in_valid = 1'b0;
      checks++;
      if ({b_chk_err, b_vec_cnt, b_done} !== {1'b1, 16'hFFFF, 1'b0}) begin
         errors++; $display("FAIL sat_last: err/vec/done=%b/%0d/%b want 1/65535/0", b_chk_err, b_vec_cnt, b_done);
      end
      step();
      checks++;
      if ({b_done, b_pass, b_err_cnt} !== {2'b10, 16'hFFFF}) begin
         errors++; $display("FAIL sat_final: done/pass/err=%b/%b/%h want 1/0/ffff", b_done, b_pass, b_err_cnt);
      end
      checks++;
      if ({a_done, a_pass, a_vec_cnt, a_err_cnt} !== {2'b10, 16'd3, 16'd3}) begin
         errors++; $display("FAIL sat_a_capped: done/pass/vec/err=%b/%b/%0d/%0d want 1/0/3/3", a_done, a_pass, a_vec_cnt, a_err_cnt);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
      inp1 = '0; inp2 = '0; carryin = 1'b0; sum = '0; carryout = 1'b0;
      test_reset();
      test_basic();
      test_boundary();
      test_capture();
      test_stop();
      test_start_drop();
      test_rst_midrun();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
